// File: rtl/alu4_chain_seq.sv
// Nibble-serial sequencer for a 4-bit ALU: splits a WIDTH-bit operation into NIB passes, chaining carries LSB first.
// Optional signed-overflow output res_ovf is built in when ALU4_CHAIN_SEQ_OVF_EN is defined.
module alu4_chain_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic             req_cin,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             alu_s2,
    output logic             alu_s1,
    output logic             alu_s0,
    output logic             alu_cin,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_g,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_g,
    output logic             res_cout,
`ifdef ALU4_CHAIN_SEQ_OVF_EN
    output logic             res_ovf,
`endif
    output logic             res_zero
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [KW-1:0]    k;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] g_next;
    logic             last_nib;
    logic             accept;

    assign last_nib = (k == KW'(NIB - 1));
    assign accept   = (state == IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // The ALU is only driven while RUN; carry_reg holds req_cin for nibble 0 and the chained carry afterwards.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        alu_s2     = 1'b0;
        alu_s1     = 1'b0;
        alu_s0     = 1'b0;
        alu_cin    = 1'b0;
        alu_a      = 4'h0;
        alu_b      = 4'h0;
        g_next     = res_g;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = RUN;
            end
            RUN: begin
                {alu_s2, alu_s1, alu_s0} = op_reg;
                alu_a   = a_reg[{k, 2'b00} +: 4];
                alu_b   = b_reg[{k, 2'b00} +: 4];
                alu_cin = ~op_reg[2] & carry_reg;
                g_next[{k, 2'b00} +: 4] = alu_g;
                if (last_nib)
                    state_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ALU4_CHAIN_SEQ_OVF_EN
    logic y_msb;

    // MSB of the operand the ALU actually adds to A, chosen by {S1,S0}.
    always_comb begin
        y_msb = 1'b0;
        case (op_reg[1:0])
            2'b00: y_msb = 1'b0;
            2'b01: y_msb = b_reg[WIDTH-1];
            2'b10: y_msb = ~b_reg[WIDTH-1];
            2'b11: y_msb = 1'b1;
            default: y_msb = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            res_g     <= '0;
            res_cout  <= 1'b0;
            res_zero  <= 1'b0;
`ifdef ALU4_CHAIN_SEQ_OVF_EN
            res_ovf   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_reg    <= req_op;
                a_reg     <= req_a;
                b_reg     <= req_b;
                carry_reg <= req_cin;
                k         <= '0;
            end
            if (state == RUN) begin
                res_g     <= g_next;
                carry_reg <= alu_cout;
                k         <= last_nib ? '0 : k + 1'b1;
                // Flags latch on the final nibble so they only change together with res_g.
                if (last_nib) begin
                    res_cout <= ~op_reg[2] & alu_cout;
                    res_zero <= (g_next == '0);
`ifdef ALU4_CHAIN_SEQ_OVF_EN
                    res_ovf  <= ~op_reg[2] & (alu_cout ^ (a_reg[WIDTH-1] ^ y_msb ^ alu_g[3]));
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu4_chain_seq.sv
// Directed table-driven bench for alu4_chain_seq at WIDTH=16 with a combinational 4-bit ALU model.
// Overflow checks are compiled in when ALU4_CHAIN_SEQ_OVF_EN is defined.
module tb_alu4_chain_seq;

    typedef struct {
        logic [2:0]  op;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic        cout;
        logic        zero;
        logic        ovf;
        logic [3:0]  hist;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic        req_cin = 1'b0;
    logic [15:0] req_a = 16'h0;
    logic [15:0] req_b = 16'h0;
    logic        alu_s2, alu_s1, alu_s0, alu_cin;
    logic [3:0]  alu_a, alu_b, alu_g;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_g;
    logic        res_cout;
    logic        res_zero;
`ifdef ALU4_CHAIN_SEQ_OVF_EN
    logic        res_ovf;
`endif

    logic [3:0]  model_y;
    logic [4:0]  model_sum;

    int          n_checks = 0;
    int          n_passed = 0;
    vec_t        vecs[14];

    alu4_chain_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
        .alu_s2(alu_s2), .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_cin(alu_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_g(alu_g), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_g(res_g), .res_cout(res_cout),
`ifdef ALU4_CHAIN_SEQ_OVF_EN
        .res_ovf(res_ovf),
`endif
        .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    // Reference 4-bit ALU: arithmetic A+Y+Cin for S2=0, bitwise logic for S2=1.
    always_comb begin
        model_y = 4'h0;
        case ({alu_s1, alu_s0})
            2'b00: model_y = 4'h0;
            2'b01: model_y = alu_b;
            2'b10: model_y = ~alu_b;
            default: model_y = 4'hF;
        endcase
        model_sum = {1'b0, alu_a} + {1'b0, model_y} + {4'b0000, alu_cin};
        alu_g     = model_sum[3:0];
        alu_cout  = model_sum[4];
        if (alu_s2) begin
            alu_cout = 1'b0;
            case ({alu_s1, alu_s0})
                2'b00: alu_g = alu_a & alu_b;
                2'b01: alu_g = alu_a | alu_b;
                2'b10: alu_g = alu_a ^ alu_b;
                default: alu_g = ~alu_a;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_passed++;
        else
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic startOp(input vec_t v);
        int waited = 0;
        req_op    = v.op;
        req_cin   = v.cin;
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("accept wait", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Entered #1 after the acceptance edge; counts edges to res_valid and records alu_cin per nibble.
    task automatic waitResult(input string tag, input vec_t v);
        int         lat = 0;
        logic [3:0] hist = 4'b0000;
        while (!res_valid && lat < 50) begin
            if (lat < 4)
                hist[lat[1:0]] = alu_cin;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, lat, 32'd4);
        checkOutput({tag, " alu_cin chain"}, {28'b0, hist}, {28'b0, v.hist});
        checkOutput({tag, " res_g"}, {16'b0, res_g}, {16'b0, v.g});
        checkOutput({tag, " res_cout"}, {31'b0, res_cout}, {31'b0, v.cout});
        checkOutput({tag, " res_zero"}, {31'b0, res_zero}, {31'b0, v.zero});
`ifdef ALU4_CHAIN_SEQ_OVF_EN
        checkOutput({tag, " res_ovf"}, {31'b0, res_ovf}, {31'b0, v.ovf});
`endif
        checkOutput({tag, " alu idle in DONE"},
                    {20'b0, alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}, 32'd0);
    endtask

    task automatic releaseResult(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checkOutput({tag, " released valid/ready"}, {30'b0, res_valid, req_ready}, 32'd1);
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        startOp(v);
        waitResult(tag, v);
        releaseResult(tag);
    endtask

    initial begin
        //             op      cin   a         b         g         cout  zero  ovf   hist
        vecs[0]  = '{3'b001, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[1]  = '{3'b010, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 4'b0001};
        vecs[2]  = '{3'b001, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 4'b1110};
        vecs[3]  = '{3'b110, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[4]  = '{3'b000, 1'b1, 16'h1234, 16'hFFFF, 16'h1235, 1'b0, 1'b0, 1'b0, 4'b0001};
        vecs[5]  = '{3'b011, 1'b0, 16'h0000, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[6]  = '{3'b011, 1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 4'b1111};
        vecs[7]  = '{3'b100, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[8]  = '{3'b101, 1'b1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[9]  = '{3'b111, 1'b0, 16'h1234, 16'h5555, 16'hEDCB, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[10] = '{3'b100, 1'b1, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[11] = '{3'b001, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 4'b0000};
        vecs[12] = '{3'b001, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 4'b1110};
        vecs[13] = '{3'b010, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1, 4'b0001};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("reset res_g/cout/zero", {14'b0, res_g, res_cout, res_zero}, 32'd0);
        checkOutput("reset alu outputs",
                    {20'b0, alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}, 32'd0);
        rst = 1'b0;

        // res_ready pulsed in IDLE must not disturb anything.
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checkOutput("idle res_ready ignored", {30'b0, req_ready, res_valid}, 32'd2);

        for (int i = 0; i < 14; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result frozen for 3 cycles while a second request waits.
        startOp(vecs[0]);
        waitResult("bp first", vecs[0]);
        req_op    = vecs[1].op;
        req_cin   = vecs[1].cin;
        req_a     = vecs[1].a;
        req_b     = vecs[1].b;
        req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp stall%0d valid/ready", c), {30'b0, res_valid, req_ready}, 32'd2);
            checkOutput($sformatf("bp stall%0d res_g", c), {16'b0, res_g}, {16'b0, vecs[0].g});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checkOutput("bp release valid/ready", {30'b0, res_valid, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("bp held request accepted", {31'b0, req_ready}, 32'd0);
        waitResult("bp second", vecs[1]);
        releaseResult("bp second");

        // Reset in the second RUN cycle discards the operation.
        startOp(vecs[2]);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrun reset valid/ready", {30'b0, res_valid, req_ready}, 32'd1);
        checkOutput("midrun reset res_g", {16'b0, res_g}, 32'd0);
        checkOutput("midrun reset alu idle",
                    {20'b0, alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrun reset no result", {31'b0, res_valid}, 32'd0);
        applyStimulus("post reset", vecs[12]);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
